// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the intersection signal logic:
//   - phase_e: phase-state codes of the intersection scheduler
//   - RED/YELLOW/GREEN: bit positions inside a 3-bit signal-head vector
//   - *_DEF: default phase durations in ticks, also reused by the
//     per-approach light/display logic
//   - head(): packs separate red/yellow/green bits into a head vector
package traffic_pkg;

    typedef enum logic [3:0] {
        ST_STARTUP     = 4'd0,
        ST_MAIN_GREEN  = 4'd1,
        ST_MAIN_YELLOW = 4'd2,
        ST_ALLRED_1    = 4'd3,
        ST_SIDE_RY     = 4'd4,
        ST_SIDE_GREEN  = 4'd5,
        ST_SIDE_YELLOW = 4'd6,
        ST_ALLRED_2    = 4'd7,
        ST_MAIN_RY     = 4'd8
    } phase_e;

    localparam int RED    = 0;
    localparam int YELLOW = 1;
    localparam int GREEN  = 2;

    localparam logic [3:0] T_STARTUP_DEF    = 4'd6;
    localparam logic [3:0] T_MAIN_MIN_DEF   = 4'd9;
    localparam logic [3:0] T_YELLOW_DEF     = 4'd3;
    localparam logic [3:0] T_ALLRED_DEF     = 4'd1;
    localparam logic [3:0] T_RED_YELLOW_DEF = 4'd2;
    localparam logic [3:0] T_SIDE_DEF       = 4'd7;

    function automatic logic [2:0] head(input logic red, input logic yellow,
                                        input logic green);
        logic [2:0] h;
        h         = 3'b000;
        h[RED]    = red;
        h[YELLOW] = yellow;
        h[GREEN]  = green;
        return h;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer
//   4-bit phase counter shared by all scheduler states.
//   Ports:
//     clk, rst_n  - clock, synchronous active-low reset
//     clear       - state entry: counter and saturation flag return to 0
//     tick        - time-base enable; the counter only moves on tick
//     sat_en      - the current state holds at its limit instead of leaving
//     limit       - T-1 of the current state
//     cnt         - ticks elapsed in the current state
//     done        - cnt has reached limit
//     sat         - a tick has arrived while at the limit with sat_en set
module phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       tick,
    input  logic       sat_en,
    input  logic [3:0] limit,
    output logic [3:0] cnt,
    output logic       done,
    output logic       sat
);

    logic [3:0] cnt_q, cnt_d;
    logic       sat_q, sat_d;

    // The counter never moves past limit: in timed states the state
    // leaves on that tick (and clear wins), in the saturating state it
    // simply holds and records that the minimum time has been served.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            cnt_d = 4'd0;
            sat_d = 1'b0;
        end else if (tick) begin
            if (cnt_q == limit) begin
                if (sat_en) begin
                    sat_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == limit);
    assign sat  = sat_q;

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Timed phase machine driving a main-road and a side-road signal head,
//   with side-road vehicle demand and optional pedestrian demand.
//   Build option: define PED_EN to compile in the pedestrian path
//   (ped_req latch, served flag, ped_walk). Without it ped_req is ignored
//   and ped_walk is tied low.
//   Ports:
//     clk, rst_n   - clock, synchronous active-low reset
//     tick         - one-cycle time-base enable
//     side_req     - side-road vehicle sensor (level or pulse)
//     ped_req      - pedestrian button (level or pulse)
//     main_lights  - main head {green, yellow, red}
//     side_lights  - side head {green, yellow, red}
//     ped_walk     - walk signal for crossing the main road
//     countdown    - ticks remaining in the current phase
//     phase        - current state code (also the FSM debug view)
//   Handshake: none; tick is a qualifier sampled on every clock edge, and
//   requests are latched on any edge regardless of tick.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_STARTUP    = T_STARTUP_DEF,
    parameter logic [3:0] T_MAIN_MIN   = T_MAIN_MIN_DEF,
    parameter logic [3:0] T_YELLOW     = T_YELLOW_DEF,
    parameter logic [3:0] T_ALLRED     = T_ALLRED_DEF,
    parameter logic [3:0] T_RED_YELLOW = T_RED_YELLOW_DEF,
    parameter logic [3:0] T_SIDE       = T_SIDE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       ped_walk,
    output logic [3:0] countdown,
    output logic [3:0] phase
);

    function automatic logic [3:0] phase_len(input logic [3:0] st);
        logic [3:0] len;
        case (st)
            ST_STARTUP:     len = T_STARTUP;
            ST_MAIN_GREEN:  len = T_MAIN_MIN;
            ST_MAIN_YELLOW: len = T_YELLOW;
            ST_ALLRED_1:    len = T_ALLRED;
            ST_SIDE_RY:     len = T_RED_YELLOW;
            ST_SIDE_GREEN:  len = T_SIDE;
            ST_SIDE_YELLOW: len = T_YELLOW;
            ST_ALLRED_2:    len = T_ALLRED;
            ST_MAIN_RY:     len = T_RED_YELLOW;
            default:        len = 4'd1;
        endcase
        return len;
    endfunction

    logic [3:0] state_q, state_d;
    logic       blink_q, blink_d;
    logic       pending_q, pending_d;
    logic [3:0] cnt;
    logic       done;
    logic       sat;
    logic [3:0] limit;
    logic       advance;
    logic       enter_side_ry;
    logic       req_any;

    assign limit   = phase_len(state_q) - 4'd1;
    assign advance = tick && done;

    phase_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_d != state_q),
        .tick   (tick),
        .sat_en (state_q == ST_MAIN_GREEN),
        .limit  (limit),
        .cnt    (cnt),
        .done   (done),
        .sat    (sat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STARTUP:     if (advance) state_d = ST_MAIN_GREEN;
            // Leaves only after the minimum green has been served and
            // demand is already latched.
            ST_MAIN_GREEN:  if (advance && pending_q) state_d = ST_MAIN_YELLOW;
            ST_MAIN_YELLOW: if (advance) state_d = ST_ALLRED_1;
            ST_ALLRED_1:    if (advance) state_d = ST_SIDE_RY;
            ST_SIDE_RY:     if (advance) state_d = ST_SIDE_GREEN;
            ST_SIDE_GREEN:  if (advance) state_d = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: if (advance) state_d = ST_ALLRED_2;
            ST_ALLRED_2:    if (advance) state_d = ST_MAIN_RY;
            ST_MAIN_RY:     if (advance) state_d = ST_MAIN_GREEN;
            default:        state_d = ST_STARTUP;
        endcase
    end

    assign enter_side_ry = (state_d == ST_SIDE_RY) && (state_q != ST_SIDE_RY);

    always_comb begin
        // Blink restarts at 0 whenever STARTUP is (re)entered.
        blink_d = 1'b0;
        if ((state_q == ST_STARTUP) && (state_d == ST_STARTUP)) begin
            blink_d = blink_q ^ tick;
        end
        // A request arriving on the clearing edge survives the clear.
        pending_d = req_any | (pending_q & ~enter_side_ry);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_STARTUP;
            blink_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blink_q   <= blink_d;
            pending_q <= pending_d;
        end
    end

`ifdef PED_EN
    logic ped_pending_q, ped_pending_d;
    logic ped_served_q, ped_served_d;
    logic enter_side_green;

    assign enter_side_green = (state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN);
    assign req_any          = side_req | ped_req;

    // ped_pending is cleared on the SIDE_RY entry edge, so its value is
    // snapshotted there; on SIDE_GREEN entry any button press made during
    // SIDE_RY is merged in. The result is the walk decision for this cycle.
    always_comb begin
        ped_pending_d = ped_req | (ped_pending_q & ~enter_side_ry);
        ped_served_d  = ped_served_q;
        if (enter_side_ry) begin
            ped_served_d = ped_pending_q;
        end else if (enter_side_green) begin
            ped_served_d = ped_served_q | ped_pending_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pending_q <= 1'b0;
            ped_served_q  <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_served_q  <= ped_served_d;
        end
    end

    assign ped_walk = (state_q == ST_SIDE_GREEN) && ped_served_q;
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign req_any        = side_req;
    assign ped_walk       = 1'b0;
`endif

    // Moore decode of the registered state.
    always_comb begin
        main_lights = 3'b000;
        side_lights = 3'b000;
        countdown   = phase_len(state_q) - cnt;
        case (state_q)
            ST_STARTUP: begin
                main_lights = head(1'b0, blink_q, 1'b0);
                side_lights = head(1'b0, blink_q, 1'b0);
            end
            ST_MAIN_GREEN: begin
                main_lights = head(1'b0, 1'b0, 1'b1);
                side_lights = head(1'b1, 1'b0, 1'b0);
                if (sat) begin
                    countdown = 4'd0;
                end
            end
            ST_MAIN_YELLOW: begin
                main_lights = head(1'b0, 1'b1, 1'b0);
                side_lights = head(1'b1, 1'b0, 1'b0);
            end
            ST_ALLRED_1, ST_ALLRED_2: begin
                main_lights = head(1'b1, 1'b0, 1'b0);
                side_lights = head(1'b1, 1'b0, 1'b0);
            end
            ST_SIDE_RY: begin
                main_lights = head(1'b1, 1'b0, 1'b0);
                side_lights = head(1'b1, 1'b1, 1'b0);
            end
            ST_SIDE_GREEN: begin
                main_lights = head(1'b1, 1'b0, 1'b0);
                side_lights = head(1'b0, 1'b0, 1'b1);
            end
            ST_SIDE_YELLOW: begin
                main_lights = head(1'b1, 1'b0, 1'b0);
                side_lights = head(1'b0, 1'b1, 1'b0);
            end
            ST_MAIN_RY: begin
                main_lights = head(1'b1, 1'b1, 1'b0);
                side_lights = head(1'b1, 1'b0, 1'b0);
            end
            default: begin
                countdown = 4'd0;
            end
        endcase
    end

    assign phase = state_q;

endmodule
